// File: rtl/reg_bank_sb_pkg.sv
// Shared constants for the register bank with issue scoreboard.
package reg_bank_sb_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_ADDR  = 0;
endpackage

// File: rtl/reg_bank_sb_if.sv
// Read/write/issue bus between a pipeline front end (master) and the register bank (slave).
interface reg_bank_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              RegEn;
    logic [ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] RR1;
    logic [ADDR_W-1:0] RR2;
    logic [DATA_W-1:0] RD1;
    logic [DATA_W-1:0] RD2;
    logic              IssueValid;
    logic [ADDR_W-1:0] IssueRd;
    logic              Hazard;
    logic              IssueAccept;
    logic [ADDR_W:0]   PendingCnt;

    modport master (
        output RegEn, WriteRegister, WriteData, RR1, RR2, IssueValid, IssueRd,
        input  RD1, RD2, Hazard, IssueAccept, PendingCnt
    );
    modport slave (
        input  RegEn, WriteRegister, WriteData, RR1, RR2, IssueValid, IssueRd,
        output RD1, RD2, Hazard, IssueAccept, PendingCnt
    );
endinterface

// File: rtl/reg_bank_sb_scoreboard.sv
// Pending-write bits per register, hazard detection and reservation count.
module reg_scoreboard
    import reg_bank_sb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [ADDR_W-1:0] rr1_i,
    input  logic [ADDR_W-1:0] rr2_i,
    input  logic              iss_valid_i,
    input  logic [ADDR_W-1:0] iss_rd_i,
    output logic              hazard_o,
    output logic              accept_o,
    output logic [ADDR_W:0]   cnt_o
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pend_q, pend_d;
    logic [DEPTH-1:0] clr_mask, set_mask, eff_pend;
    logic [ADDR_W:0]  cnt_q, cnt_d;
    logic             up, down;

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (wr_en_i) clr_mask[wr_addr_i] = 1'b1;
        // A write landing this cycle already satisfies its consumer when data is forwarded.
        eff_pend = (BYPASS != 0) ? (pend_q & ~clr_mask) : pend_q;
        hazard_o = eff_pend[rr1_i] | eff_pend[rr2_i] | (iss_valid_i & eff_pend[iss_rd_i]);
        accept_o = iss_valid_i & ~hazard_o;
        if (accept_o && !(ZERO_REG != 0 && iss_rd_i == ADDR_W'(ZERO_ADDR)))
            set_mask[iss_rd_i] = 1'b1;
        pend_d = (pend_q & ~clr_mask) | set_mask;
        // At most one bit rises and one falls per cycle, so the count moves by -1..+1.
        up    = |(set_mask & ~pend_q);
        down  = |(clr_mask & pend_q & ~set_mask);
        cnt_d = cnt_q + (ADDR_W+1)'(up) - (ADDR_W+1)'(down);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/reg_bank_sb.sv
// Two-read, one-write register bank with write forwarding and an issue scoreboard.
module reg_bank_sb
    import reg_bank_sb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic         clk,
    input logic         rst_n,
    reg_bank_sb_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] banco_q;
    logic [1:0][ADDR_W-1:0]       rr;
    logic [1:0][DATA_W-1:0]       rd;
    logic                         wr_ok;

    assign wr_ok = bus.RegEn && !(ZERO_REG != 0 && bus.WriteRegister == ADDR_W'(ZERO_ADDR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     banco_q <= '0;
        else if (wr_ok) banco_q[bus.WriteRegister] <= bus.WriteData;
    end

    assign rr = {bus.RR2, bus.RR1};

    always_comb begin
        rd = '0;
        for (int p = 0; p < 2; p++) begin
            if (ZERO_REG != 0 && rr[p] == ADDR_W'(ZERO_ADDR))
                rd[p] = '0;
            else if (BYPASS != 0 && wr_ok && bus.WriteRegister == rr[p])
                rd[p] = bus.WriteData;
            else
                rd[p] = banco_q[rr[p]];
        end
    end

    assign bus.RD1 = rd[0];
    assign bus.RD2 = rd[1];

    reg_scoreboard #(
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (bus.RegEn),
        .wr_addr_i  (bus.WriteRegister),
        .rr1_i      (bus.RR1),
        .rr2_i      (bus.RR2),
        .iss_valid_i(bus.IssueValid),
        .iss_rd_i   (bus.IssueRd),
        .hazard_o   (bus.Hazard),
        .accept_o   (bus.IssueAccept),
        .cnt_o      (bus.PendingCnt)
    );
endmodule

// File: tb/tb_reg_bank_sb.sv
// Scoreboard bench: driver pushes model predictions, monitor pops and compares each cycle.
module tb_reg_bank_sb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 32;

    typedef struct {
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic          haz;
        logic          acc;
        logic [AW:0]   cnt;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_bank_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    reg_bank_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    exp_t          expq[$];
    logic [DW-1:0] m_regs[N];
    bit            m_pend[N];
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_cnt();
        int c = 0;
        foreach (m_pend[i]) c += int'(m_pend[i]);
        return c;
    endfunction

    // Reference: a register is "busy" unless a write lands on it this very cycle.
    function automatic bit m_busy(input int a, input bit we, input int wa);
        return m_pend[a] && !(we && wa == a);
    endfunction

    function automatic logic [DW-1:0] m_read(input int a, input bit we, input int wa,
                                             input logic [DW-1:0] wd);
        if (a == 0) return '0;
        if (we && wa == a) return wd;
        return m_regs[a];
    endfunction

    task automatic cycle(input bit rst, input bit we, input int wa, input logic [DW-1:0] wd,
                         input int r1, input int r2, input bit iv, input int ird);
        exp_t e;
        @(negedge clk);
        rst_n             = !rst;
        bus.RegEn         = we;
        bus.WriteRegister = AW'(wa);
        bus.WriteData     = wd;
        bus.RR1           = AW'(r1);
        bus.RR2           = AW'(r2);
        bus.IssueValid    = iv;
        bus.IssueRd       = AW'(ird);
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            foreach (m_pend[i]) m_pend[i] = 1'b0;
        end
        e.rd1 = m_read(r1, we, wa, wd);
        e.rd2 = m_read(r2, we, wa, wd);
        e.haz = m_busy(r1, we, wa) || m_busy(r2, we, wa) || (iv && m_busy(ird, we, wa));
        e.acc = iv && !e.haz;
        e.cnt = (AW+1)'(m_cnt());
        expq.push_back(e);
        if (!rst) begin
            if (we) begin
                if (wa != 0) m_regs[wa] = wd;
                m_pend[wa] = 1'b0;
            end
            if (e.acc && ird != 0) m_pend[ird] = 1'b1;
        end
    endtask

    task automatic idle(input int r1, input int r2);
        cycle(0, 0, 0, '0, r1, r2, 0, 0);
    endtask

    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("RD1", bus.RD1, e.rd1);
                chk("RD2", bus.RD2, e.rd2);
                chk("Hazard", DW'(bus.Hazard), DW'(e.haz));
                chk("IssueAccept", DW'(bus.IssueAccept), DW'(e.acc));
                chk("PendingCnt", DW'(bus.PendingCnt), DW'(e.cnt));
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : drv
        int wa, r1, r2, ird;
        bus.RegEn = 0; bus.WriteRegister = '0; bus.WriteData = '0;
        bus.RR1 = '0; bus.RR2 = '0; bus.IssueValid = 0; bus.IssueRd = '0;

        cycle(1, 0, 0, '0, 0, 0, 0, 0);
        #3 chk("reset PendingCnt", DW'(bus.PendingCnt), 0);
        idle(0, 0);

        // write r5, forwarded to RD2 in the same cycle, stored for RD1 next cycle
        cycle(0, 1, 5, 32'hDEADBEEF, 0, 5, 0, 0);
        #3 chk("bypass RD2", bus.RD2, 32'hDEADBEEF);
        idle(5, 0);
        #3 chk("stored RD1", bus.RD1, 32'hDEADBEEF);

        // zero register
        cycle(0, 1, 0, 32'h1234, 0, 0, 0, 0);
        idle(0, 0);
        #3 chk("r0 reads zero", bus.RD1, 0);
        cycle(0, 0, 0, '0, 0, 0, 1, 0);
        #3 chk("r0 issue accepted", DW'(bus.IssueAccept), 1);
        idle(0, 0);
        #3 chk("r0 issue no reservation", DW'(bus.PendingCnt), 0);

        // basic reservation lifecycle on r7
        cycle(0, 0, 0, '0, 0, 0, 1, 7);
        idle(7, 0);
        #3 chk("r7 hazard", DW'(bus.Hazard), 1);
        chk("r7 count", DW'(bus.PendingCnt), 1);
        cycle(0, 1, 7, 32'h77, 7, 0, 0, 0);
        #3 chk("r7 cleared by same-cycle write", DW'(bus.Hazard), 0);
        idle(0, 0);
        #3 chk("r7 count cleared", DW'(bus.PendingCnt), 0);

        // WAW on r3
        cycle(0, 0, 0, '0, 0, 0, 1, 3);
        cycle(0, 0, 0, '0, 0, 0, 1, 3);
        #3 chk("WAW blocked", DW'(bus.IssueAccept), 0);
        cycle(0, 1, 3, 32'h33, 0, 0, 1, 3);
        #3 chk("WAW write+issue accepted", DW'(bus.IssueAccept), 1);
        idle(3, 0);
        #3 chk("WAW bit stays set", DW'(bus.Hazard), 1);
        chk("WAW count unchanged", DW'(bus.PendingCnt), 1);
        cycle(0, 1, 3, 32'h34, 0, 0, 0, 0);

        // fill every nonzero register, then drain
        for (int i = 1; i < N; i++) cycle(0, 0, 0, '0, 0, 0, 1, i);
        idle(0, 0);
        #3 chk("fill count", DW'(bus.PendingCnt), 31);
        cycle(0, 0, 0, '0, 0, 0, 1, 0);
        idle(0, 0);
        #3 chk("fill no wrap", DW'(bus.PendingCnt), 31);
        for (int i = 1; i < N; i++) cycle(0, 1, i, DW'(i * 16'h101), 0, 0, 0, 0);
        idle(0, 0);
        #3 chk("drain count", DW'(bus.PendingCnt), 0);

        // reset mid-operation
        cycle(0, 1, 5, 32'hCAFEF00D, 0, 0, 1, 7);
        cycle(0, 0, 0, '0, 0, 0, 1, 9);
        cycle(1, 0, 0, '0, 5, 7, 0, 0);
        #3 chk("reset RD1", bus.RD1, 0);
        chk("reset RD2", bus.RD2, 0);
        chk("reset count", DW'(bus.PendingCnt), 0);
        chk("reset hazard", DW'(bus.Hazard), 0);
        idle(5, 9);

        // randomized traffic over a narrow address window to provoke conflicts
        for (int n = 0; n < 600; n++) begin
            wa  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : int'($urandom_range(0, 7));
            r1  = $urandom_range(0, 7);
            r2  = $urandom_range(0, 7);
            ird = $urandom_range(0, 7);
            cycle(($urandom_range(0, 99) == 0), $urandom_range(0, 2) == 0, wa, $urandom,
                  ($urandom_range(0, 1) == 0) ? r1 : 0, ($urandom_range(0, 1) == 0) ? r2 : 0,
                  $urandom_range(0, 1) == 1, ird);
        end
        idle(0, 0);

        for (int k = 0; k < 10 && expq.size() > 0; k++) @(negedge clk);
        #4;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected responses left unchecked", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_bank_sb.md
REG_BANK_SB -- requirements
Module: reg_bank_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_REG, default 1, when 1 register 0 is hardwired to zero.
REQ-004 SHALL have parameter BYPASS, default 1, when 1 same-cycle write data is forwarded to the read ports.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port RegEn  input  1  write enable.
REQ-008 SHALL have port WriteRegister  input  ADDR_W  write address.
REQ-009 SHALL have port WriteData  input  DATA_W  write data.
REQ-010 SHALL have ports RR1, RR2  input  ADDR_W  read addresses.
REQ-011 SHALL have ports RD1, RD2  output  DATA_W  read data.
REQ-012 SHALL have port IssueValid  input  1  an instruction requests to reserve a destination register.
REQ-013 SHALL have port IssueRd  input  ADDR_W  destination register to reserve.
REQ-014 SHALL have port Hazard  output  1  a source or destination conflicts with a pending write.
REQ-015 SHALL have port IssueAccept  output  1  the reservation is taken this cycle.
REQ-016 SHALL have port PendingCnt  output  ADDR_W+1  number of registers currently reserved.

Function
REQ-017 SHALL perform writes on rising clk when RegEn=1: Banco[WriteRegister] <= WriteData.
REQ-018 SHALL ignore writes to address 0 when ZERO_REG=1; RD of address 0 SHALL read 0.
REQ-019 SHALL provide combinational reads with zero-cycle latency: RDn = Banco[RRn].
REQ-020 SHALL forward WriteData to RDn when BYPASS=1, RegEn=1, WriteRegister==RRn, and the address is not a hardwired zero; with BYPASS=0, new data SHALL appear the cycle after the write.
REQ-021 SHALL keep a pending bit per register: set on an accepted issue to IssueRd, cleared on a write (RegEn) to that address.
REQ-022 SHALL give set priority when an accepted issue and a write target the same register in the same cycle: the bit ends at 1.
REQ-023 SHALL never set the pending bit for register 0 when ZERO_REG=1; an issue to register 0 SHALL be accepted without reservation.
REQ-024 SHALL drive Hazard = pending[RR1] | pending[RR2] | (IssueValid & pending[IssueRd]), after same-cycle clears by a write are applied when BYPASS=1.
REQ-025 SHALL drive IssueAccept = IssueValid & ~Hazard.
REQ-026 SHALL update PendingCnt each cycle as +1 on a new set, -1 on a clear of a set bit, net 0 when both occur; the range is 0..2**ADDR_W-1 with no wrap.
REQ-027 SHALL treat a write to a non-pending register as a plain write: no counter change and no error.

Reset
REQ-028 SHALL, on rst_n=0, asynchronously clear all registers to 0, all pending bits to 0 and PendingCnt to 0; Hazard and IssueAccept then follow combinationally from the cleared state.
REQ-029 SHALL abandon in-flight reservations on reset mid-operation; the first edge after deassertion SHALL behave as a normal cycle.

Structure
REQ-030 SHALL place the parameter defaults (DATA_W, ADDR_W) and the zero-register address constant in the shared core package.
REQ-031 SHALL implement the pending-bit vector and PendingCnt as a sub-module reg_scoreboard; storage and bypass SHALL reside in the top module.

Verification
REQ-032 SHALL cover reset: after writes and issues, pulse rst_n low -> RD1=RD2=0, PendingCnt=0, Hazard=0.
REQ-033 SHALL cover write and read: write 0xDEADBEEF to r5, then RR1=5 next cycle -> RD1=0xDEADBEEF; with RegEn and RR2=5 in the same cycle (BYPASS=1) -> RD2=new data immediately.
REQ-034 SHALL cover the zero register: write 0x1234 to r0 -> RD1(r0)=0; issue to r0 -> IssueAccept=1, PendingCnt unchanged.
REQ-035 SHALL cover the scoreboard: issue r7 -> PendingCnt=1; RR1=7 -> Hazard=1; write r7 -> Hazard=0, PendingCnt=0.
REQ-036 SHALL cover WAW: with r3 pending, issue r3 -> IssueAccept=0; with r3 pending and a same-cycle write to r3 plus issue r3 -> bit ends at 1, PendingCnt unchanged.
REQ-037 SHALL cover the fill boundary: reserve all 31 nonzero registers -> PendingCnt=31 with no wrap; clear all -> PendingCnt=0.
